// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory controller.
//   DATA_W    : RAM/data word width
//   mem_op_e  : funct3 access codes carried on data_mem_control
//   state_e   : controller FSM states
package dmem_pkg;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_op_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_DATA,
        MERGE,
        WR,
        RESP
    } state_e;
endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: selects the addressed byte/half of a RAM word and extends it.
//   word   : 32-bit RAM read word
//   lane   : addr[1:0] of the access (little-endian lane select)
//   funct3 : access code; B/H sign-extend, BU/HU zero-extend, W passes through
//   result : extended 32-bit load value
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        lane,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] result
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b      = word[{lane, 3'b000} +: 8];
        h      = word[{lane[1], 4'b0000} +: 16];
        result = funct3 == MEM_B  ? {{24{b[7]}}, b}  :
                 funct3 == MEM_BU ? {24'b0, b}       :
                 funct3 == MEM_H  ? {{16{h[15]}}, h} :
                 funct3 == MEM_HU ? {16'b0, h}       : word;
    end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: executes core load/store requests against a single-port word RAM.
//   Request : req_valid/req_ready, mem_write, data_mem_control (funct3), addr, wdata
//   Response: rsp_valid (one-cycle pulse, no back-pressure), rdata, rsp_err
//   RAM     : ram_en, ram_we, ram_addr, ram_wdata, ram_rdata (1-cycle read latency)
//   Optional: DMEM_BYTE_ENABLE_EN adds ram_be and writes sub-words directly
//             instead of read-modify-write.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mem_write,
    input  logic [2:0]        data_mem_control,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              rsp_valid,
    output logic [31:0]       rdata,
    output logic              rsp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
`ifdef DMEM_BYTE_ENABLE_EN
    output logic [3:0]        ram_be,
`endif
    input  logic [31:0]       ram_rdata
);
    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wword_q, wword_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       ld_word;
    logic [31:0]       merged;
    logic              bad;
    logic              unused_addr_hi;
`ifdef DMEM_BYTE_ENABLE_EN
    logic [3:0]        be_q, be_d;
`endif

    // Upper address bits are dropped on purpose: accesses wrap modulo RAM size.
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    dmem_load_align u_align (
        .word   (ram_rdata),
        .lane   (addr_q[1:0]),
        .funct3 (op_q),
        .result (ld_word)
    );

    always_comb begin
        bad = data_mem_control == 3'b011 || data_mem_control[2:1] == 2'b11 ||
              (mem_write && data_mem_control[2]) ||
              (data_mem_control[1:0] == 2'b01 && addr[0]) ||
              (data_mem_control[1:0] == 2'b10 && addr[1:0] != 2'b00);
    end

    // Sub-word store merge: overwrite the addressed lane(s) of the word just read.
    always_comb begin
        merged = ram_rdata;
        if (op_q[0])
            merged[{addr_q[1], 4'b0000} +: 16] = wword_q[15:0];
        else
            merged[{addr_q[1:0], 3'b000} +: 8] = wword_q[7:0];
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wword_d = wword_q;
        rdata_d = rdata_q;
`ifdef DMEM_BYTE_ENABLE_EN
        be_d    = be_q;
`endif
        case (state_q)
            IDLE: if (req_valid) begin
                op_d   = data_mem_control;
                we_d   = mem_write;
                err_d  = bad;
                addr_d = addr[ADDR_W+1:0];
`ifdef DMEM_BYTE_ENABLE_EN
                wword_d = data_mem_control[1] ? wdata :
                          data_mem_control[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
                be_d    = data_mem_control[1] ? 4'b1111 :
                          data_mem_control[0] ? 4'b0011 << {addr[1], 1'b0} :
                                                4'b0001 << addr[1:0];
                state_d = bad ? RESP : !mem_write ? RD : WR;
`else
                wword_d = wdata;
                state_d = bad ? RESP : !mem_write ? RD :
                          data_mem_control == MEM_W ? WR : RD;
`endif
                if (bad)
                    rdata_d = '0;
            end
            RD:      state_d = we_q ? MERGE : RD_DATA;
            RD_DATA: begin
                rdata_d = ld_word;
                state_d = RESP;
            end
            MERGE:   begin
                wword_d = merged;
                state_d = WR;
            end
            WR:      begin
                rdata_d = '0;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wword_q <= '0;
            rdata_q <= '0;
`ifdef DMEM_BYTE_ENABLE_EN
            be_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wword_q <= wword_d;
            rdata_q <= rdata_d;
`ifdef DMEM_BYTE_ENABLE_EN
            be_q    <= be_d;
`endif
        end
    end

    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign rsp_err   = err_q && state_q == RESP;
    assign rdata     = rdata_q;
    assign ram_en    = state_q == RD || state_q == WR;
    assign ram_we    = state_q == WR;
    assign ram_addr  = addr_q[ADDR_W+1:2];
    assign ram_wdata = wword_q;
`ifdef DMEM_BYTE_ENABLE_EN
    assign ram_be    = ram_we ? be_q : 4'b0000;
`endif
endmodule
